// File: rtl/int_controller_pkg.sv
// Shared definitions for the interrupt controller: register window offsets
// and the dispatch state machine encoding.
package int_controller_pkg;

    localparam logic [7:0] OFF_CTRL = 8'd0;
    localparam logic [7:0] OFF_MASK = 8'd1;
    localparam logic [7:0] OFF_PEND = 8'd2;
    localparam logic [7:0] OFF_ACT  = 8'd3;
    localparam logic [7:0] OFF_VEC0 = 8'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        RESUME  = 2'd3
    } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest-indexed set bit of the eligible vector wins.
module int_prio_enc #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] elig_i,
    output logic               valid_o,
    output logic [2:0]         id_o
);

    // Scan from the top down so the lowest index is the last assignment.
    always_comb begin
        valid_o = 1'b0;
        id_o    = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                valid_o = 1'b1;
                id_o    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: captures source edges, arbitrates by fixed priority and
// sequences the CPU interrupt entry/return handshake; configured over the data bus.
module int_controller
    import int_controller_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cpu_ret,
    input  logic [7:0]         bus_addr,
    input  logic               bus_w_en,
    input  logic [7:0]         bus_w_data,
    output logic [7:0]         bus_r_data,
    output logic               int_req,
    output logic [7:0]         int_en,
    output logic [7:0]         int_vec,
    output logic               busy
);

    localparam int WIN = 4 + NUM_SRC;

    state_e             state_q, state_d;
    logic               ctrl_q, ctrl_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] irq_q;
    logic [7:0]         vec_q [NUM_SRC];
    logic [7:0]         vec_d [NUM_SRC];
    logic [2:0]         id_q, id_d;
    logic [7:0]         vecOut_q, vecOut_d;

    logic [7:0]         off;
    logic               inWin;
    logic               wr;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] elig;
    logic               winValid;
    logic [2:0]         winId;
    logic               dispatch;

    assign off   = bus_addr - BASE_ADDR;
    assign inWin = (bus_addr >= BASE_ADDR) && (off < 8'(WIN));
    assign wr    = bus_w_en && inWin;
    assign edges = irq_src & ~irq_q;
    assign elig  = pend_q & mask_q & {NUM_SRC{ctrl_q}};

    int_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .elig_i  (elig),
        .valid_o (winValid),
        .id_o    (winId)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ctrl_q   <= 1'b0;
            mask_q   <= '0;
            pend_q   <= '0;
            irq_q    <= '0;
            vec_q    <= '{default: '0};
            id_q     <= 3'd0;
            vecOut_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            irq_q    <= irq_src;
            vec_q    <= vec_d;
            id_q     <= id_d;
            vecOut_q <= vecOut_d;
        end
    end

    // Dispatch FSM; the winner's vector and id are frozen on leaving IDLE.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        vecOut_d = vecOut_q;
        dispatch = 1'b0;
        case (state_q)
            IDLE: begin
                if (winValid) begin
                    dispatch = 1'b1;
                    id_d     = winId;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (winId == 3'(i)) begin
                            vecOut_d = vec_q[i];
                        end
                    end
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = SERVICE;
            end
            SERVICE: begin
                if (cpu_ret) begin
                    state_d = RESUME;
                end
            end
            RESUME: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register writes and pending update; a fresh edge beats any clear in the same cycle.
    always_comb begin
        ctrl_d = ctrl_q;
        mask_d = mask_q;
        pend_d = pend_q;
        vec_d  = vec_q;
        if (wr) begin
            case (off)
                OFF_CTRL: ctrl_d = bus_w_data[0];
                OFF_MASK: mask_d = bus_w_data[NUM_SRC-1:0];
                OFF_PEND: pend_d = pend_q & ~bus_w_data[NUM_SRC-1:0];
                default: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (off == OFF_VEC0 + 8'(i)) begin
                            vec_d[i] = bus_w_data;
                        end
                    end
                end
            endcase
        end
        if (dispatch) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (winId == 3'(i)) begin
                    pend_d[i] = 1'b0;
                end
            end
        end
        pend_d = pend_d | edges;
    end

    always_comb begin
        bus_r_data = 8'd0;
        if (inWin) begin
            case (off)
                OFF_CTRL: bus_r_data = {7'd0, ctrl_q};
                OFF_MASK: bus_r_data = 8'(mask_q);
                OFF_PEND: bus_r_data = 8'(pend_q);
                OFF_ACT:  bus_r_data = {busy, 4'd0, id_q};
                default: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (off == OFF_VEC0 + 8'(i)) begin
                            bus_r_data = vec_q[i];
                        end
                    end
                end
            endcase
        end
    end

    assign int_req = (state_q == REQ);
    assign busy    = (state_q == REQ) || (state_q == SERVICE);
    assign int_en  = {7'd0, ctrl_q};
    assign int_vec = vecOut_q;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: scoreboard of expected dispatches,
// one task per scenario.
module tb_int_controller;

    typedef struct packed {
        logic [7:0] vec;
        logic [2:0] id;
    } exp_t;

    logic       clock;
    logic       rst_n;
    logic [3:0] irq_src;
    logic       cpu_ret;
    logic [7:0] bus_addr;
    logic       bus_w_en;
    logic [7:0] bus_w_data;
    logic [7:0] bus_r_data;
    logic       int_req;
    logic [7:0] int_en;
    logic [7:0] int_vec;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    int_controller #(
        .NUM_SRC   (4),
        .BASE_ADDR (8'hF0)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .cpu_ret    (cpu_ret),
        .bus_addr   (bus_addr),
        .bus_w_en   (bus_w_en),
        .bus_w_data (bus_w_data),
        .bus_r_data (bus_r_data),
        .int_req    (int_req),
        .int_en     (int_en),
        .int_vec    (int_vec),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        bus_addr   = addr;
        bus_w_data = data;
        bus_w_en   = 1'b1;
        tick();
        bus_w_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        bus_addr = addr;
        #1;
        data = bus_r_data;
    endtask

    task automatic do_ret();
        cpu_ret = 1'b1;
        tick();
        cpu_ret = 1'b0;
    endtask

    // Waits a bounded number of cycles for int_req, then checks latency, vector and ACTIVE.
    task automatic wait_dispatch(input int expLat, input string name);
        int         n = 0;
        exp_t       e;
        logic [7:0] rd;
        while (int_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (int_req !== 1'b1 || n != expLat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d cycles (int_req=%b), expected %0d", name, n, int_req, expLat);
        end
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: empty at dispatch", name);
        end else begin
            e = sbq.pop_front();
            checks++;
            if (int_vec !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s int_vec: got %h, expected %h", name, int_vec, e.vec);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s busy in REQ: got %b, expected 1", name, busy);
            end
            bus_read(8'hF3, rd);
            checks++;
            if (rd !== {1'b1, 4'd0, e.id}) begin
                errors++;
                $display("[TB] FAIL %s ACTIVE: got %h, expected %h", name, rd, {1'b1, 4'd0, e.id});
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({int_req, busy, int_vec, int_en} !== 18'd0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got req=%b busy=%b vec=%h en=%h, expected all 0", int_req, busy, int_vec, int_en);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(8'hF0 + 8'(a), rd);
            checks++;
            if (rd !== 8'd0) begin
                errors++;
                $display("[TB] FAIL reset reg[%0d]: got %h, expected 00", a, rd);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] rd;
        bus_write(8'hF5, 8'h40);
        bus_write(8'hF1, 8'h02);
        bus_write(8'hF0, 8'h01);
        sbq.push_back('{vec: 8'h40, id: 3'd1});
        irq_src[1] = 1'b1;
        wait_dispatch(2, "basic");
        bus_read(8'hF2, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL basic PENDING: got %h, expected 00", rd);
        end
        irq_src[1] = 1'b0;
        tick();
        checks++;
        if (int_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic one-cycle req: got req=%b busy=%b, expected req=0 busy=1", int_req, busy);
        end
        tick();
        tick();
        bus_read(8'hF3, rd);
        checks++;
        if (rd !== 8'h81 || int_vec !== 8'h40) begin
            errors++;
            $display("[TB] FAIL basic SERVICE hold: got ACTIVE=%h vec=%h, expected 81/40", rd, int_vec);
        end
        do_ret();
        checks++;
        if (busy !== 1'b0 || int_vec !== 8'h40) begin
            errors++;
            $display("[TB] FAIL basic RESUME: got busy=%b vec=%h, expected 0/40", busy, int_vec);
        end
        tick();
    endtask

    task automatic test_priority();
        logic [7:0] rd;
        bus_write(8'hF4, 8'h10);
        bus_write(8'hF6, 8'h22);
        bus_write(8'hF1, 8'h05);
        sbq.push_back('{vec: 8'h10, id: 3'd0});
        sbq.push_back('{vec: 8'h22, id: 3'd2});
        irq_src[0] = 1'b1;
        irq_src[2] = 1'b1;
        wait_dispatch(2, "prio_src0");
        bus_read(8'hF2, rd);
        checks++;
        if (rd !== 8'h04) begin
            errors++;
            $display("[TB] FAIL prio PENDING after first: got %h, expected 04", rd);
        end
        irq_src[0] = 1'b0;
        irq_src[2] = 1'b0;
        tick();
        tick();
        checks++;
        if (int_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio held in SERVICE: got req=%b busy=%b, expected 0/1", int_req, busy);
        end
        do_ret();
        checks++;
        if (int_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio RESUME gap: got req=%b busy=%b, expected 0/0", int_req, busy);
        end
        wait_dispatch(2, "prio_src2");
        tick();
        do_ret();
        tick();
    endtask

    task automatic test_masked();
        logic [7:0] rd;
        logic       sawReq = 1'b0;
        bus_write(8'hF1, 8'h00);
        bus_write(8'hF7, 8'h33);
        irq_src[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            sawReq |= int_req;
        end
        checks++;
        if (sawReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL masked no-req: got int_req seen=%b, expected 0", sawReq);
        end
        bus_read(8'hF2, rd);
        checks++;
        if (rd !== 8'h08) begin
            errors++;
            $display("[TB] FAIL masked PENDING: got %h, expected 08", rd);
        end
        irq_src[3] = 1'b0;
        sbq.push_back('{vec: 8'h33, id: 3'd3});
        bus_write(8'hF1, 8'h08);
        wait_dispatch(1, "unmask");
        tick();
        do_ret();
        tick();
    endtask

    task automatic test_w1c_race();
        logic [7:0] rd;
        bus_write(8'hF1, 8'h00);
        irq_src[1] = 1'b0;
        tick();
        irq_src[1] = 1'b1;
        bus_write(8'hF2, 8'h02);
        bus_read(8'hF2, rd);
        checks++;
        if (rd !== 8'h02) begin
            errors++;
            $display("[TB] FAIL w1c race: got PENDING=%h, expected 02", rd);
        end
        bus_write(8'hF2, 8'h02);
        bus_read(8'hF2, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL w1c plain clear: got PENDING=%h, expected 00", rd);
        end
        irq_src[1] = 1'b0;
        tick();
    endtask

    task automatic test_ctrl_clear_hazard();
        logic [7:0] rd;
        bus_write(8'hF1, 8'h02);
        sbq.push_back('{vec: 8'h40, id: 3'd1});
        irq_src[1] = 1'b1;
        wait_dispatch(2, "hazard");
        checks++;
        if (int_en !== 8'h01) begin
            errors++;
            $display("[TB] FAIL hazard int_en in REQ: got %h, expected 01", int_en);
        end
        bus_write(8'hF0, 8'h00);
        bus_write(8'hF5, 8'h77);
        bus_write(8'hF1, 8'h00);
        irq_src[1] = 1'b0;
        bus_read(8'hF3, rd);
        checks++;
        if (int_en !== 8'h00 || busy !== 1'b1 || int_vec !== 8'h40 || rd !== 8'h81) begin
            errors++;
            $display("[TB] FAIL hazard SERVICE: got en=%h busy=%b vec=%h ACTIVE=%h, expected 00/1/40/81", int_en, busy, int_vec, rd);
        end
        do_ret();
        tick();
        checks++;
        if (busy !== 1'b0 || int_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hazard return: got busy=%b req=%b, expected 0/0", busy, int_req);
        end
    endtask

    task automatic test_reset_mid_service();
        logic [7:0] rd;
        logic       sawReq = 1'b0;
        bus_write(8'hF1, 8'h02);
        bus_write(8'hF0, 8'h01);
        sbq.push_back('{vec: 8'h77, id: 3'd1});
        irq_src[1] = 1'b1;
        wait_dispatch(2, "pre_reset");
        tick();
        irq_src[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({int_req, busy, int_vec, int_en} !== 18'd0) begin
            errors++;
            $display("[TB] FAIL async reset outputs: got req=%b busy=%b vec=%h en=%h, expected all 0", int_req, busy, int_vec, int_en);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(8'hF0 + 8'(a), rd);
            checks++;
            if (rd !== 8'd0) begin
                errors++;
                $display("[TB] FAIL async reset reg[%0d]: got %h, expected 00", a, rd);
            end
        end
        tick();
        rst_n = 1'b1;
        tick();
        irq_src[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            sawReq |= int_req;
        end
        checks++;
        if (sawReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post-reset no-req: got int_req seen=%b, expected 0", sawReq);
        end
        bus_read(8'hF2, rd);
        checks++;
        if (rd !== 8'h02) begin
            errors++;
            $display("[TB] FAIL post-reset PENDING: got %h, expected 02", rd);
        end
        irq_src[1] = 1'b0;
        bus_write(8'hF2, 8'hFF);
    endtask

    task automatic test_idle_ret_and_window();
        logic [7:0] rd;
        cpu_ret = 1'b1;
        tick();
        cpu_ret = 1'b0;
        tick();
        bus_read(8'hF3, rd);
        checks++;
        if (busy !== 1'b0 || int_req !== 1'b0 || rd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL idle ret: got busy=%b req=%b ACTIVE=%h, expected 0/0/00", busy, int_req, rd);
        end
        bus_write(8'hF1, 8'hFF);
        bus_write(8'hF0, 8'hFF);
        bus_write(8'hF7, 8'h5A);
        bus_read(8'hF1, rd);
        checks++;
        if (rd !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL MASK width: got %h, expected 0F", rd);
        end
        bus_read(8'hF0, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++;
            $display("[TB] FAIL CTRL width: got %h, expected 01", rd);
        end
        bus_read(8'hF7, rd);
        checks++;
        if (rd !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL VEC3 readback: got %h, expected 5A", rd);
        end
        bus_write(8'hF8, 8'hAA);
        bus_read(8'hF8, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL above window: got %h, expected 00", rd);
        end
        bus_read(8'hEF, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL below window: got %h, expected 00", rd);
        end
        checks++;
        if (int_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle stays quiet: got int_req=%b, expected 0", int_req);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        irq_src    = 4'd0;
        cpu_ret    = 1'b0;
        bus_addr   = 8'd0;
        bus_w_en   = 1'b0;
        bus_w_data = 8'd0;
        test_reset();
        test_basic();
        test_priority();
        test_masked();
        test_w1c_race();
        test_ctrl_clear_hazard();
        test_reset_mid_service();
        test_idle_ret_and_window();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
